// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, column
// drive patterns, debug struct and key decoding.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } keypad_state_e;

  typedef struct packed {
    keypad_state_e state;
    logic          fifo_full;
  } keypad_dbg_t;

  localparam logic [3:0] COL_PAT [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic logic one_low(input logic [3:0] row);
    return row inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
  endfunction

  // Callers guarantee exactly one low row bit; the priority only picks its index.
  function automatic logic [3:0] key_map(input logic [1:0] idx, input logic [3:0] row);
    logic [1:0] r;
    logic [3:0] code;
    if (!row[0])      r = 2'd0;
    else if (!row[1]) r = 2'd1;
    else if (!row[2]) r = 2'd2;
    else              r = 2'd3;
    case ({idx, r})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h4;
      4'b00_10: code = 4'h7;
      4'b00_11: code = 4'hE;
      4'b01_00: code = 4'h2;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h8;
      4'b01_11: code = 4'h0;
      4'b10_00: code = 4'h3;
      4'b10_01: code = 4'h6;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hF;
      4'b11_00: code = 4'hA;
      4'b11_01: code = 4'hB;
      4'b11_10: code = 4'hC;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Key event stream from the scanner to its consumer.
// key_valid/key_ready: an entry transfers on every clk edge where both are
// high; key_code is stable while key_valid is high and key_ready is low.
interface keypad_key_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overflow;

  modport master (output key_code, key_valid, key_held, overflow, input key_ready);
  modport slave  (input key_code, key_valid, key_held, overflow, output key_ready);
endinterface

// File: rtl/keypad_scan_ctrl_fifo.sv
// Small synchronous FIFO for key events. A push while full is dropped and
// flagged, unless a pop frees the slot in the same cycle.
module key_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             pop_ok, push_ok;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign overflow = push && !push_ok;
  assign pop_data = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d = wr_q + 1'b1;
    end
    if (pop_ok) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: tick-paced column scan, press/release debounce and a
// queued key event output.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int DEBOUNCE   = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    row,
  output logic [3:0]    col,
  input  logic          scan_en,
  keypad_key_if.master  kif,
  output keypad_dbg_t   dbg
);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE + 1);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;
  keypad_state_e     state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        row_q, row_d;
  logic [3:0]        col_q, col_d;
  logic              push;
  logic [3:0]        push_code;
  logic              fifo_full, fifo_empty, fifo_ovf;
  logic [3:0]        fifo_code;

  assign tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    push      = 1'b0;
    push_code = key_map(idx_q, row_q);
    if (!scan_en) begin
      state_d = ST_IDLE;
      col_d   = 4'b0000;
    end else if (tick) begin
      case (state_q)
        ST_IDLE: begin
          col_d = 4'b0000;
          if (row != 4'hF) begin
            state_d = ST_SCAN;
            idx_d   = 2'd0;
            col_d   = COL_PAT[0];
          end
        end
        ST_SCAN: begin
          if (one_low(row)) begin
            row_d = row;
            cnt_d = CNT_W'(1);
            if (DEBOUNCE == 1) begin
              push      = 1'b1;
              push_code = key_map(idx_q, row);
              state_d   = ST_PRESSED;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else if (idx_q == 2'd3) begin
            state_d = ST_IDLE;
            col_d   = 4'b0000;
          end else begin
            idx_d = idx_q + 2'd1;
            col_d = COL_PAT[idx_q + 2'd1];
          end
        end
        ST_DEBOUNCE: begin
          if (row == row_q) begin
            // cnt_q counts agreeing samples so far; this tick is one more.
            if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
              push    = 1'b1;
              state_d = ST_PRESSED;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = ST_IDLE;
            col_d   = 4'b0000;
          end
        end
        ST_PRESSED: begin
          if (row == 4'hF) begin
            cnt_d = CNT_W'(1);
            if (DEBOUNCE == 1) begin
              state_d = ST_IDLE;
              col_d   = 4'b0000;
            end else begin
              state_d = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (row != 4'hF) begin
            state_d = ST_PRESSED;
          end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
            state_d = ST_IDLE;
            col_d   = 4'b0000;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          col_d   = 4'b0000;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      row_q      <= 4'hF;
      col_q      <= 4'b0000;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
    end
  end

  key_fifo #(.WIDTH(4), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_code),
    .full      (fifo_full),
    .pop       (kif.key_ready),
    .pop_data  (fifo_code),
    .empty     (fifo_empty),
    .overflow  (fifo_ovf)
  );

  assign col           = col_q;
  assign kif.key_code  = fifo_code;
  assign kif.key_valid = !fifo_empty;
  assign kif.key_held  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);
  assign kif.overflow  = fifo_ovf;
  assign dbg.state     = state_q;
  assign dbg.fifo_full = fifo_full;
endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Single-clock controller that owns the 4x4 matrix keypad. It generates its own scan tick from the system clock rather than a derived clock, and sequences the column drive. It debounces press and release over a programmable number of ticks and queues decoded key codes in a small FIFO with a valid/ready output. It sits between the keypad pins and the Morse decoder front end, replacing free-running scan logic with an event-based interface.

## Interface
- TICK_DIV, 50000: clk cycles per scan tick (1 ms at 50 MHz); minimum 2.
- DEBOUNCE, 20: consecutive agreeing tick samples required to accept a press or a release; minimum 1.
- FIFO_DEPTH, 4: key event queue depth; power of two, minimum 2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- row  in  4  keypad rows, active low, externally pulled up.
- col  out  4  keypad column drive, active low.
- scan_en  in  1  enables scanning; when low the FSM is held in IDLE.
- key_code  out  4  code at the FIFO head.
- key_valid  out  1  FIFO not empty.
- key_ready  in  1  consumer accepts; pop when key_valid && key_ready.
- key_held  out  1  high in PRESSED and RELEASE.
- overflow  out  1  one-cycle pulse when a press is dropped because the FIFO is full.

## Operation
- Tick counter counts 0..TICK_DIV-1; `tick` is high for one cycle at count TICK_DIV-1. The first tick occurs TICK_DIV cycles after reset release.
- FSM states: IDLE, SCAN, DEBOUNCE, PRESSED, RELEASE. Transitions occur only on tick cycles, with one exception: scan_en low forces IDLE on the next clk.
- **IDLE**: col=0000. On tick, if row!=1111, go to SCAN with idx=0 and col=1110.
- **SCAN**: col drives column idx low (1110, 1101, 1011, 0111). On tick:
  - row has exactly one 0: latch row and go to DEBOUNCE with cnt=1. If DEBOUNCE==1, push and go directly to PRESSED.
  - otherwise, if idx==3: go to IDLE.
  - otherwise: idx+1 and drive the next column.
- **DEBOUNCE**: column held. On tick:
  - row equals the latched row: cnt+1. When cnt reaches DEBOUNCE, push the code and go to PRESSED.
  - row differs: go to IDLE with no push.
- **PRESSED**: column held. On tick with row==1111, go to RELEASE with cnt=1; if DEBOUNCE==1, go directly to IDLE.
- **RELEASE**: on tick with row==1111, cnt+1; at DEBOUNCE go to IDLE. On tick with row!=1111, return to PRESSED.
- A key is pushed once per press. Holding a key never repeats.
- Multi-row (chorded) readings are never accepted as keys.
- Key map (col idx / row bit):
  - idx0: rows 0..3 → 1, 4, 7, E
  - idx1: rows 0..3 → 2, 5, 8, 0
  - idx2: rows 0..3 → 3, 6, 9, F
  - idx3: rows 0..3 → A, B, C, D
- FIFO behaviour:
  - Push when full: the event is dropped and overflow pulses for that cycle.
  - Push and pop in the same cycle while full: pop first, and the push is accepted.
  - FIFO contents survive scan_en low. Only rst_n clears them.

## Timing
- Reset values: col=0000, key_code=0, key_valid=0, key_held=0, overflow=0; FSM in IDLE, tick counter 0, FIFO empty.
- Assertion of rst_n is immediate (asynchronous). Release of rst_n is synchronised by the integrator.
- col is registered and changes in the cycle after a tick. Rows are sampled on the next tick, giving one full tick of settle time.
- Push happens on the accepting tick. key_valid and key_code are valid the following cycle.
- Press latency in ticks: 1 (detect in IDLE) + (idx+1) (scan to the pressed column) + (DEBOUNCE-1).
- Pop takes effect on the valid&&ready edge. The next entry, or key_valid=0 if none, appears the following cycle.
- Reset mid-press: all state and FIFO contents are lost, and the held key is re-detected from IDLE after reset.

## Structure
- Package `keypad_pkg`:
  - FSM state enum.
  - column drive constants COL_PAT[0:3].
  - function `key_map(idx, row)` returning the 4-bit code.
  - function `one_low(row)`.
- Sub-module `key_fifo`: synchronous FIFO with parameters WIDTH=4 and DEPTH, providing push/full and pop/empty plus the overflow pulse.
- The tick counter, FSM, debounce counter and column register live in the top module.

## Test plan
All scenarios use TICK_DIV=4 and DEBOUNCE=3, with ticks at cycles 4, 8, 12, and so on. The bench models row[r]=0 iff key (r,c) is pressed and col[c]=0.
- **Press and hold key 5 from cycle 0, key_ready=1**:
  - SCAN at tick 4, col 1101 from cycle 9, DEBOUNCE from tick 12, push at tick 20.
  - key_valid=1 and key_code=5 at cycle 21, for exactly one cycle.
  - No further push while held; key_held=1.
- **Release key 5 after push**: RELEASE then IDLE after 3 release ticks, key_held drops to 0, col returns to 0000.
- **Bounce: press key D for 2 ticks in DEBOUNCE, then release**: no push, FSM back to IDLE, key_valid stays 0.
- **key_ready=0, five distinct presses (1,2,3,A,0)**:
  - The FIFO holds 1, 2, 3, A.
  - overflow pulses for 0.
  - Then key_ready=1 pops 1, 2, 3, A in order.
- **Keys 1 and 4 pressed together (col0, two rows low)**: never accepted; SCAN wraps to IDLE with no push.
- **Edge cases**:
  - rst_n low mid-DEBOUNCE: all outputs take reset values immediately.
  - scan_en low mid-DEBOUNCE: IDLE with col=0000 on the next clk, and FIFO contents are retained.
